uart_msg_scheduler: RTL and testbench
=====================================

// Module: uart_msg_scheduler
// PURPOSE
//  Shares one byte-level UART transmitter between N_REQ message sources (e.g. POLO
//  responder, status reporter, debug echo). Round-robin arbitration at message
//  boundaries; grant locked until the byte flagged last has been transmitted.
//  Sequences each byte into the transmitter and enforces an idle gap between messages.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  GAP_TICKS  2   baud_tick periods of forced idle after each message (0 = no gap)
// PORTS
//  clk        in   1        system clock (single clock domain)
//  rst        in   1        synchronous reset, active-high
//  baud_tick  in   1        1-cycle pulse per bit period (shared with transmitter)
//  req_valid  in   N_REQ    requester i has a byte on req_data[8i+7:8i]
//  req_data   in   8*N_REQ  packed byte per requester
//  req_last   in   N_REQ    byte of requester i is the final byte of its message
//  req_ready  out  N_REQ    byte of requester i accepted this cycle (combinational)
//  tx_data    out  8        byte for transmitter, stable from tx_start until tx_busy falls
//  tx_start   out  1        1-cycle pulse: transmitter loads tx_data
//  tx_busy    in   1        transmitter busy; rises >=1 cycle after tx_start
//  grant      out  N_REQ    one-hot owner of the transmitter, 0 when idle
//  active     out  1        high in any state other than IDLE
//  msg_done   out  1        1-cycle pulse when last byte of a message finishes
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, tx_data=0, tx_start=0, grant=0, msg_done=0,
//   gap count=0, rr pointer=N_REQ-1 (requester 0 wins first). Applies mid-message:
//   message is abandoned, no msg_done; partially sent byte is the transmitter's problem.
//  FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP:
//  - IDLE: if any req_valid, grant <= first requester with valid searching from
//    rr_ptr+1 upward (wrap at N_REQ); rr_ptr <= winner; -> SEND. 1 cycle arb latency.
//  - SEND: req_ready[g] = req_valid[g] (only granted bit may be 1, only in SEND).
//    On accept: tx_data <= byte, last_r <= req_last[g], tx_start <= 1 (next cycle only),
//    -> WAIT_BUSY. If req_valid[g]=0: stay, grant held (source stall, no timeout).
//  - WAIT_BUSY: wait for tx_busy=1 -> WAIT_DONE. tx_start high exactly 1 cycle.
//  - WAIT_DONE: on tx_busy=0: if last_r: msg_done pulse, grant <= 0,
//    -> GAP (GAP_TICKS>0, count cleared) or IDLE (GAP_TICKS=0); else -> SEND.
//  - GAP: count baud_tick; at count==GAP_TICKS-1 and baud_tick -> IDLE.
//  - Non-granted requesters never see req_ready; requests arriving mid-message wait.
//  - Simultaneous requests: round-robin strictly; a source cannot win twice in a row
//    while another source is requesting at the IDLE decision cycle.
//  - Single-byte message (valid & last on first byte) is legal.
//  - Min byte-to-byte spacing: SEND->WAIT_BUSY->WAIT_DONE->SEND; no byte overlap.
//  - Gap counter width: $clog2(GAP_TICKS+1), saturating is not required (cleared on entry).
// TESTING
//  1 req0 sends 0x50,0x4F,0x4C,0x4F,0x0A(last) -> 5 tx_start pulses, bytes in order,
//    grant=4'b0001 throughout, one msg_done after 5th tx_busy fall, then GAP_TICKS ticks idle.
//  2 req1 and req3 valid same cycle after reset -> req1 served fully first, then req3;
//    re-assert req1 at end -> req3's successor order is req1 (wrap).
//  3 req2 drops valid for 20 cycles mid-message -> state stays SEND, grant=4'b0100,
//    tx_start stays 0, req0 requesting meanwhile gets no req_ready.
//  4 rst pulsed while WAIT_DONE on byte 3 -> next cycle grant=0, active=0, tx_start=0,
//    no msg_done; next request after reset arbitrated from requester 0.
//  5 GAP_TICKS=0 build, back-to-back single-byte messages from req0 and req1 ->
//    second tx_start follows first tx_busy fall with no baud_tick wait.
//  6 tx_busy held low for 10 cycles after tx_start -> FSM waits in WAIT_BUSY, no re-pulse.

Source files
------------

// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: shares one byte-level UART transmitter between N_REQ message
// sources with round-robin arbitration at message boundaries and an idle gap after each.
module uart_msg_scheduler #(
  parameter int N_REQ     = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [N_REQ-1:0]     grant,
  output logic                 active,
  output logic                 msg_done
);

  localparam int PW = $clog2(N_REQ);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_win;
  logic [GW-1:0]   gap_cnt;
  logic            last_r;
  logic            accept;
  logic            msg_end;
  logic [7:0]      owner_byte;

  // rr_ptr always names the current (or most recent) owner, so the search starts just past it
  function automatic logic [PW-1:0] rr_pick(input logic [PW-1:0] ptr,
                                            input logic [N_REQ-1:0] v);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx_p;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx   = (int'(ptr) + i) % N_REQ;
      idx_p = PW'(idx);
      if (!found && v[idx_p]) begin
        pick  = idx_p;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign rr_win     = rr_pick(rr_ptr, req_valid);
  assign accept     = (state == SEND) && req_valid[rr_ptr];
  assign msg_end    = (state == WAIT_DONE) && !tx_busy && last_r;
  assign owner_byte = req_data[{rr_ptr, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (|req_valid) state_nxt = SEND;
      SEND:      if (accept) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_r) state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
          else        state_nxt = SEND;
        end
      end
      GAP:       if (baud_tick && (gap_cnt == GAP_LAST)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    active    = (state != IDLE);
    if (state == SEND) req_ready = grant & req_valid;
  end

  // tx_data only changes on acceptance, which keeps it stable for the whole transmission
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      tx_start <= 1'b0;
      grant    <= '0;
      msg_done <= 1'b0;
      last_r   <= 1'b0;
      gap_cnt  <= '0;
      rr_ptr   <= PW'(N_REQ - 1);
    end else begin
      tx_start <= accept;
      msg_done <= msg_end;
      if ((state == IDLE) && (|req_valid)) begin
        rr_ptr <= rr_win;
        grant  <= N_REQ'(1) << rr_win;
      end
      if (msg_end) grant <= '0;
      if (accept) begin
        tx_data <= owner_byte;
        last_r  <= req_last[rr_ptr];
      end
      if (msg_end) begin
        gap_cnt <= '0;
      end else if ((state == GAP) && baud_tick) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// tb_uart_msg_scheduler: directed and randomized checks of the scheduler against a
// queue-based message model, plus a gap-free instance for back-to-back timing.
module tb_uart_msg_scheduler;

  localparam int N   = 4;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           baud_tick;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy, active, msg_done;

  logic [N-1:0]   z_valid, z_last, z_ready, z_grant;
  logic [8*N-1:0] z_data;
  logic [7:0]     z_tx_data;
  logic           z_tx_start, z_busy, z_active, z_msg_done;

  always #5 clk = ~clk;

  uart_msg_scheduler #(.N_REQ(N), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .active(active), .msg_done(msg_done)
  );

  uart_msg_scheduler #(.N_REQ(N), .GAP_TICKS(0)) dut_nogap (
    .clk(clk), .rst(rst), .baud_tick(1'b0),
    .req_valid(z_valid), .req_data(z_data), .req_last(z_last), .req_ready(z_ready),
    .tx_data(z_tx_data), .tx_start(z_tx_start), .tx_busy(z_busy),
    .grant(z_grant), .active(z_active), .msg_done(z_msg_done)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [N][$];
  logic [8:0] mdl_q [N][$];
  bit         hold [N];
  bit         stall_en;
  int         busy_delay_force;

  int         mdl_ptr, pending_done, tx_count, done_count, ticks_since_done, owner;
  bit         in_msg, inflight, prev_start, prev_busy, gap_watch;
  logic [8:0] mon_item, drv_item;
  logic [N-1:0] acc;

  int         cnt, t0, d0, cyc, z_starts, z_dones, fall_cyc, start2_cyc;
  bit         prev_zb;
  logic [N-1:0] r_now, r_prev;
  logic [7:0] polo [5];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int src, input logic [7:0] b, input logic last);
    src_q[src].push_back({last, b});
    mdl_q[src].push_back({last, b});
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic int pick_owner();
    for (int k = 1; k <= N; k++) begin
      if (mdl_q[(mdl_ptr + k) % N].size() > 0) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic waitIdle(input int budget);
    int n;
    bit busy_any;
    n = 0;
    busy_any = 1'b1;
    while (busy_any && n < budget) begin
      tick();
      n++;
      busy_any = (n < 3) || active || tx_busy || in_msg || (pending_done != 0);
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0 || mdl_q[i].size() > 0) busy_any = 1'b1;
    end
    checkOutput("wait_idle_timeout", busy_any, 1'b0);
  endtask

  // Sources present the head of their queue; a granted source may randomly stall
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && !hold[i] &&
            !(grant[i] && stall_en && $urandom_range(3) == 0)) begin
          drv_item           = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = drv_item[7:0];
          req_last[i]        = drv_item[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      acc = req_ready;
    end
  end

  initial begin
    int d1;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        d1 = (busy_delay_force > 0) ? busy_delay_force : int'($urandom_range(1, 3));
        repeat (d1) @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    z_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (z_tx_start) begin
        repeat (2) @(negedge clk);
        z_busy = 1'b1;
        repeat (3) @(negedge clk);
        z_busy = 1'b0;
      end
    end
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  // Every transmitted byte must be the next byte of the message the model expects
  always @(posedge clk) begin
    #1;
    if (inflight && prev_busy && !tx_busy) inflight = 1'b0;
    prev_busy = tx_busy;
    if (msg_done) begin
      checkOutput("msg_done_expected", pending_done > 0, 1'b1);
      if (pending_done > 0) pending_done--;
      done_count++;
      gap_watch        = 1'b1;
      ticks_since_done = 0;
    end else if (baud_tick) begin
      ticks_since_done++;
    end
    if (tx_start) begin
      tx_count++;
      checkOutput("tx_start_single_cycle", prev_start, 1'b0);
      checkOutput("tx_no_overlap", inflight, 1'b0);
      inflight = 1'b1;
      if (!in_msg) begin
        if (gap_watch) checkOutput("gap_ticks_honoured", ticks_since_done >= GAP, 1'b1);
        gap_watch = 1'b0;
        owner = pick_owner();
        checkOutput("message_expected", owner >= 0, 1'b1);
        if (owner >= 0) begin
          mdl_ptr = owner;
          in_msg  = 1'b1;
        end
      end
      if (in_msg && mdl_q[mdl_ptr].size() > 0) begin
        mon_item = mdl_q[mdl_ptr].pop_front();
        checkOutput("tx_data", tx_data, mon_item[7:0]);
        checkOutput("grant_owner", grant, 32'(1) << mdl_ptr);
        if (mon_item[8]) begin
          in_msg = 1'b0;
          pending_done++;
        end
      end
    end
    prev_start = tx_start;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    stall_en = 1'b0;
    busy_delay_force = 0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    mdl_ptr = N - 1;
    pending_done = 0; tx_count = 0; done_count = 0; ticks_since_done = 0;
    in_msg = 0; inflight = 0; prev_start = 0; prev_busy = 0; gap_watch = 0;
    z_valid = '0; z_last = '0; z_data = '0;
    polo = '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0A};

    repeat (3) tick();
    checkOutput("reset_grant", grant, '0);
    checkOutput("reset_active", active, 1'b0);
    checkOutput("reset_tx_start", tx_start, 1'b0);
    checkOutput("reset_msg_done", msg_done, 1'b0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] POLO message from requester 0");
    t0 = tx_count; d0 = done_count;
    for (int i = 0; i < 5; i++) applyStimulus(0, polo[i], i == 4);
    waitIdle(2000);
    checkOutput("t1_byte_count", tx_count - t0, 5);
    checkOutput("t1_msg_done_count", done_count - d0, 1);

    $display("[TB] simultaneous requests from 1 and 3, then 1 again");
    applyStimulus(1, 8'h11, 1'b0); applyStimulus(1, 8'h12, 1'b1);
    applyStimulus(3, 8'h31, 1'b0); applyStimulus(3, 8'h32, 1'b0); applyStimulus(3, 8'h33, 1'b1);
    for (cnt = 0; cnt < 500 && grant != 4'b1000; cnt++) tick();
    checkOutput("t2_req3_granted", grant, 4'b1000);
    applyStimulus(1, 8'h13, 1'b1);
    waitIdle(2000);

    $display("[TB] requester 2 stalls mid-message");
    t0 = tx_count;
    for (int i = 0; i < 5; i++) applyStimulus(2, 8'h20 + 8'(i), i == 4);
    for (cnt = 0; cnt < 500 && (tx_count - t0) < 2; cnt++) tick();
    checkOutput("t3_two_bytes_sent", tx_count - t0, 2);
    hold[2] = 1'b1;
    applyStimulus(0, 8'h01, 1'b0); applyStimulus(0, 8'h02, 1'b1);
    repeat (10) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t3_grant_held", grant, 4'b0100);
      checkOutput("t3_no_tx_start", tx_start, 1'b0);
      checkOutput("t3_no_ready", req_ready, '0);
    end
    checkOutput("t3_stalled_count", tx_count - t0, 2);
    hold[2] = 1'b0;
    waitIdle(2000);

    $display("[TB] reset during byte 3 of a message");
    t0 = tx_count; d0 = done_count;
    for (int i = 0; i < 5; i++) applyStimulus(2, 8'h40 + 8'(i), i == 4);
    for (cnt = 0; cnt < 500 && !((tx_count - t0) >= 3 && tx_busy); cnt++) tick();
    checkOutput("t4_reach_byte3", tx_count - t0, 3);
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    in_msg = 0; pending_done = 0; mdl_ptr = N - 1; gap_watch = 0;
    tick();
    checkOutput("t4_grant", grant, '0);
    checkOutput("t4_active", active, 1'b0);
    checkOutput("t4_tx_start", tx_start, 1'b0);
    checkOutput("t4_msg_done", msg_done, 1'b0);
    rst = 1'b0;
    for (cnt = 0; cnt < 100 && tx_busy; cnt++) tick();
    repeat (4) tick();
    checkOutput("t4_no_msg_done", done_count - d0, 0);
    applyStimulus(1, 8'h5A, 1'b1);
    applyStimulus(3, 8'hA5, 1'b1);
    tick();
    tick();
    checkOutput("t4_rr_from_zero", grant, 4'b0010);
    waitIdle(2000);

    $display("[TB] gap-free build, back-to-back single-byte messages");
    z_data  = {8'h00, 8'h00, 8'hB1, 8'hA0};
    z_valid = 4'b0011;
    z_last  = 4'b0011;
    cyc = 0; z_starts = 0; z_dones = 0; fall_cyc = -1; start2_cyc = -1;
    prev_zb = 0; r_prev = '0;
    for (cnt = 0; cnt < 300 && z_starts < 2; cnt++) begin
      tick();
      cyc++;
      r_now   = z_ready;
      z_valid = z_valid & ~r_prev;
      z_last  = z_last & ~r_prev;
      r_prev  = r_now;
      if (prev_zb && !z_busy && z_starts == 1 && fall_cyc < 0) fall_cyc = cyc;
      prev_zb = z_busy;
      if (z_msg_done) z_dones++;
      if (z_tx_start) begin
        z_starts++;
        if (z_starts == 1) begin
          checkOutput("t5_first_byte", z_tx_data, 8'hA0);
          checkOutput("t5_first_grant", z_grant, 4'b0001);
        end else begin
          checkOutput("t5_second_byte", z_tx_data, 8'hB1);
          checkOutput("t5_second_grant", z_grant, 4'b0010);
          start2_cyc = cyc;
        end
      end
    end
    checkOutput("t5_two_starts", z_starts, 2);
    checkOutput("t5_no_gap_latency", start2_cyc - fall_cyc, 3);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (z_msg_done) z_dones++;
    end
    checkOutput("t5_msg_done_count", z_dones, 2);
    checkOutput("t5_idle_after", z_active, 1'b0);

    $display("[TB] transmitter slow to assert busy");
    busy_delay_force = 10;
    applyStimulus(3, 8'hC3, 1'b1);
    for (cnt = 0; cnt < 500 && !tx_start; cnt++) tick();
    checkOutput("t6_tx_start_seen", tx_start, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      checkOutput("t6_no_repulse", tx_start, 1'b0);
      checkOutput("t6_active", active, 1'b1);
    end
    busy_delay_force = 0;
    waitIdle(2000);

    $display("[TB] randomized message bursts");
    stall_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int nmsg;
        nmsg = $urandom_range(0, 2);
        for (int m = 0; m < nmsg; m++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) applyStimulus(i, 8'($urandom), b == len - 1);
        end
      end
      waitIdle(6000);
    end
    stall_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
